// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key_debounce block: per-channel FSM state encoding
// and the default debounce interval (20 ms at 50 MHz).
package key_debounce_pkg;

   typedef enum logic [1:0] {
      UP           = 2'd0,
      PRESS_WAIT   = 2'd1,
      DOWN         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

   function automatic logic is_held(input state_e st);
      return (st == DOWN) || (st == RELEASE_WAIT);
   endfunction

endpackage

// File: rtl/key_debounce_chan.sv
// One pushbutton channel: two-flop synchronizer, debounce FSM with stability
// counter and registered outputs. Optional macro: KEY_DEBOUNCE_RELEASE_PULSE_EN.
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic key_i,
   output logic pressed_o,
   output logic press_pulse_o
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  ,output logic release_pulse_o
`endif
);

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed_q, pressed_d;
   logic             press_pulse_q, press_pulse_d;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
   logic             release_pulse_q, release_pulse_d;
`endif

   // Synchronizer idles at 1 (released) so a held key is re-debounced after reset.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= key_i;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         UP: begin
            if (!sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         PRESS_WAIT: begin
            if (sync2_q) begin
               state_d = UP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = DOWN;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DOWN: begin
            if (sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = CNT_ONE;
            end
         end
         RELEASE_WAIT: begin
            if (!sync2_q) begin
               state_d = DOWN;
            end else if (cnt_q == CNT_LAST) begin
               state_d = UP;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = UP;
      endcase
   end

   // Outputs lag the state by one register; a change of is_held marks the entry edge.
   always_comb begin
      pressed_d     = is_held(state_q);
      press_pulse_d = (state_q == DOWN) && !pressed_q;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      release_pulse_d = (state_q == UP) && pressed_q;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q       <= UP;
         cnt_q         <= '0;
         pressed_q     <= 1'b0;
         press_pulse_q <= 1'b0;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
         release_pulse_q <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pressed_q     <= pressed_d;
         press_pulse_q <= press_pulse_d;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
         release_pulse_q <= release_pulse_d;
`endif
      end
   end

   assign pressed_o     = pressed_q;
   assign press_pulse_o = press_pulse_q;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
   assign release_pulse_o = release_pulse_q;
`endif

endmodule

// File: rtl/key_debounce.sv
// N_KEYS independent pushbutton debouncers. Optional macro
// KEY_DEBOUNCE_RELEASE_PULSE_EN adds the release_pulse output.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int unsigned N_KEYS          = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic              CLOCK_50,
   input  logic              resetn,
   input  logic [N_KEYS-1:0] KEY,
   output logic [N_KEYS-1:0] pressed,
   output logic [N_KEYS-1:0] press_pulse
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
  ,output logic [N_KEYS-1:0] release_pulse
`endif
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk_i          (CLOCK_50),
         .rstn_i         (resetn),
         .key_i          (KEY[g]),
         .pressed_o      (pressed[g]),
         .press_pulse_o  (press_pulse[g])
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
        ,.release_pulse_o(release_pulse[g])
`endif
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed table-driven bench for key_debounce with DEBOUNCE_CYCLES = 4.
module tb_key_debounce;

   localparam int unsigned N = 4;
   localparam int unsigned D = 4;

   logic         CLOCK_50 = 1'b0;
   logic         resetn   = 1'b0;
   logic [N-1:0] KEY      = '1;
   logic [N-1:0] pressed;
   logic [N-1:0] press_pulse;
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
   logic [N-1:0] release_pulse;
`endif

   key_debounce #(
      .N_KEYS         (N),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .resetn       (resetn),
      .KEY          (KEY),
      .pressed      (pressed),
      .press_pulse  (press_pulse)
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
     ,.release_pulse(release_pulse)
`endif
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [N-1:0] key;
      logic         rstn;
      logic [N-1:0] p;
      logic [N-1:0] pp;
      logic [N-1:0] rp;
   } vec_t;

   vec_t vecs[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic add(input int n, input logic [N-1:0] key, input logic rstn,
                      input logic [N-1:0] p, input logic [N-1:0] pp, input logic [N-1:0] rp);
      vec_t v;
      v.key = key; v.rstn = rstn; v.p = p; v.pp = pp; v.rp = rp;
      for (int i = 0; i < n; i++) vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int idx, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s step=%0d actual=%b required=%b", name, idx, act, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
   task automatic step(input string tag, input int idx, input logic [N-1:0] key, input logic rstn,
                       input logic [N-1:0] p, input logic [N-1:0] pp, input logic [N-1:0] rp);
      @(negedge CLOCK_50);
      KEY    = key;
      resetn = rstn;
      @(posedge CLOCK_50);
      #1;
      chk({tag, "_pressed"}, idx, pressed, p);
      chk({tag, "_press_pulse"}, idx, press_pulse, pp);
`ifdef KEY_DEBOUNCE_RELEASE_PULSE_EN
      chk({tag, "_release_pulse"}, idx, release_pulse, rp);
`else
      if (rp !== rp) $display("unreachable");
`endif
   endtask

   initial begin
      // Reset with all keys low, then every key debounced after reset release.
      add(10, 4'b0000, 1'b0, 4'h0, 4'h0, 4'h0);
      add(6,  4'b0000, 1'b1, 4'h0, 4'h0, 4'h0);
      add(1,  4'b0000, 1'b1, 4'hF, 4'hF, 4'h0);
      add(1,  4'b0000, 1'b1, 4'hF, 4'h0, 4'h0);
      add(6,  4'b1111, 1'b1, 4'hF, 4'h0, 4'h0);
      add(1,  4'b1111, 1'b1, 4'h0, 4'h0, 4'hF);
      add(3,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h0);
      // KEY[1] pressed at cycle 0, released at cycle 20.
      add(6,  4'b1101, 1'b1, 4'h0, 4'h0, 4'h0);
      add(1,  4'b1101, 1'b1, 4'h2, 4'h2, 4'h0);
      add(13, 4'b1101, 1'b1, 4'h2, 4'h0, 4'h0);
      add(6,  4'b1111, 1'b1, 4'h2, 4'h0, 4'h0);
      add(1,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h2);
      add(2,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h0);
      // KEY[2] bounce: low 3, high 1, then low steady from cycle 4.
      add(3,  4'b1011, 1'b1, 4'h0, 4'h0, 4'h0);
      add(1,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h0);
      add(6,  4'b1011, 1'b1, 4'h0, 4'h0, 4'h0);
      add(1,  4'b1011, 1'b1, 4'h4, 4'h4, 4'h0);
      add(1,  4'b1011, 1'b1, 4'h4, 4'h0, 4'h0);
      add(6,  4'b1111, 1'b1, 4'h4, 4'h0, 4'h0);
      add(1,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h4);
      add(1,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h0);
      // KEY[0] and KEY[3] together; release with a one-cycle bounce at cycle 2.
      add(6,  4'b0110, 1'b1, 4'h0, 4'h0, 4'h0);
      add(1,  4'b0110, 1'b1, 4'h9, 4'h9, 4'h0);
      add(1,  4'b0110, 1'b1, 4'h9, 4'h0, 4'h0);
      add(2,  4'b1111, 1'b1, 4'h9, 4'h0, 4'h0);
      add(1,  4'b0110, 1'b1, 4'h9, 4'h0, 4'h0);
      add(6,  4'b1111, 1'b1, 4'h9, 4'h0, 4'h0);
      add(1,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h9);
      add(2,  4'b1111, 1'b1, 4'h0, 4'h0, 4'h0);

      for (int i = 0; i < vecs.size(); i++)
         step("tbl", i, vecs[i].key, vecs[i].rstn, vecs[i].p, vecs[i].pp, vecs[i].rp);

      // Reset pulse at cycle 3 of a KEY[0] press debounce, key held throughout.
      for (int c = 0; c < 3; c++)  step("rst_mid", c, 4'b1110, 1'b1, 4'h0, 4'h0, 4'h0);
      step("rst_mid", 3, 4'b1110, 1'b0, 4'h0, 4'h0, 4'h0);
      for (int c = 4; c < 10; c++) step("rst_mid", c, 4'b1110, 1'b1, 4'h0, 4'h0, 4'h0);
      step("rst_mid", 10, 4'b1110, 1'b1, 4'h1, 4'h1, 4'h0);
      step("rst_mid", 11, 4'b1110, 1'b1, 4'h1, 4'h0, 4'h0);

      // Reset while DOWN: no release pulse, then full re-debounce of the held key.
      step("rst_down", 0, 4'b1110, 1'b0, 4'h0, 4'h0, 4'h0);
      for (int c = 1; c < 7; c++)  step("rst_down", c, 4'b1110, 1'b1, 4'h0, 4'h0, 4'h0);
      step("rst_down", 7, 4'b1110, 1'b1, 4'h1, 4'h1, 4'h0);
      step("rst_down", 8, 4'b1110, 1'b1, 4'h1, 4'h0, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL provide parameter N_KEYS, default 4: number of pushbutton channels.
REQ-002 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable cycles required, 20 ms at 50 MHz; legal range 2 to 2^24.
REQ-003 SHALL have port CLOCK_50, input, 1 bit: 50 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port KEY, input, N_KEYS bits: raw asynchronous pushbuttons, active-low (0 = pressed).
REQ-006 SHALL have port pressed, output, N_KEYS bits: debounced level, active-high (1 = held).
REQ-007 SHALL have port press_pulse, output, N_KEYS bits: one-cycle strobe on each debounced press.
REQ-008 SHALL have port release_pulse, output, N_KEYS bits: one-cycle strobe on each debounced release; present only with the macro (REQ-024).

Function
REQ-009 SHALL pass each KEY bit through a two-flop synchronizer before any other logic.
REQ-010 SHALL run one independent debounce FSM per channel, with states UP, PRESS_WAIT, DOWN and RELEASE_WAIT.
REQ-011 UP: when synced key = 0, SHALL go to PRESS_WAIT with count = 1; otherwise stay in UP with count = 0.
REQ-012 PRESS_WAIT: synced key = 1 SHALL return to UP with count = 0; synced key = 0 with count = DEBOUNCE_CYCLES-1 SHALL go to DOWN; otherwise count increments.
REQ-013 DOWN and RELEASE_WAIT SHALL mirror REQ-011/REQ-012 with the key polarity inverted; on count expiry, RELEASE_WAIT SHALL go to UP.
REQ-014 pressed[i] SHALL be 1 exactly while channel i is in state DOWN or RELEASE_WAIT.
REQ-015 press_pulse[i] SHALL be 1 for exactly the single cycle in which channel i enters DOWN.
REQ-016 Latency SHALL be 2 + DEBOUNCE_CYCLES clock cycles from a KEY edge held stable to the change on pressed.
REQ-017 Any bounce during a WAIT state SHALL discard the partial count, with no output change and no pulse.
REQ-018 Each counter SHALL be $clog2(DEBOUNCE_CYCLES+1) bits wide and SHALL never wrap; it saturates by state exit.
REQ-019 Channels SHALL be fully independent: simultaneous events on several keys SHALL give simultaneous pulses with no cross-channel effect.
REQ-020 All outputs SHALL be registered; no combinational path from KEY to any output.

Reset
REQ-021 While resetn = 0 at a clock edge, every channel SHALL enter UP with count = 0.
REQ-022 While resetn = 0, the synchronizer flops SHALL load 1 (released), and pressed, press_pulse and release_pulse SHALL be 0.
REQ-023 Reset asserted mid-debounce or while DOWN SHALL abort with no pulse; after release of reset, a key still held SHALL be re-debounced with full latency (REQ-016).

Configuration
REQ-024 Macro KEY_DEBOUNCE_RELEASE_PULSE_EN defined: release_pulse SHALL exist and go high for the one cycle in which a channel enters UP from RELEASE_WAIT.
REQ-025 Macro undefined: port release_pulse and its registers SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-026 Package key_debounce_pkg SHALL hold the FSM state encoding (UP, PRESS_WAIT, DOWN, RELEASE_WAIT) and the default DEBOUNCE_CYCLES constant.
REQ-027 The per-channel synchronizer, FSM and counter SHALL form sub-module key_debounce_chan, instantiated N_KEYS times by a generate loop.

Verification (DEBOUNCE_CYCLES = 4, N_KEYS = 4; cycle 0 = first edge sampling the KEY change)
REQ-028 resetn = 0 for 10 cycles with KEY = 4'b0000 -> pressed = 0, press_pulse = 0 throughout, and pressed = 0 until cycle 6 after resetn rises.
REQ-029 KEY[1] goes 1->0 at cycle 0 and is held -> pressed[1] rises at cycle 6; press_pulse[1] high only in cycle 6; other bits stay 0.
REQ-030 KEY[2] low 3 cycles, high 1 cycle, then low steady -> no output during the bounce; pressed[2] and press_pulse[2] assert 6 cycles after the final falling edge.
REQ-031 KEY[0] and KEY[3] fall in the same cycle -> press_pulse = 4'b1001 in one single cycle.
REQ-032 Macro defined, KEY[1] held pressed then released at cycle 20 -> pressed[1] falls at cycle 26; release_pulse[1] high only in cycle 26. Macro undefined: same stimulus, no release_pulse port, pressed identical.
REQ-033 resetn pulsed low at cycle 3 of a press debounce -> no press_pulse; with the key still held, pressed rises 6 cycles after resetn returns to 1.
